// File: rtl/pad_cfg_pkg.sv
// pad_cfg_pkg: shared types and constants for the pad configuration controller
package pad_cfg_pkg;
   typedef struct packed {
      logic       pu;
      logic       pd;
      logic       slew;
      logic [2:0] drv;
   } pad_cfg_t;

   typedef enum logic [2:0] {PWRUP, IDLE, HOLD, APPLY, RELEASE} state_t;

   localparam logic [7:0] CFG_WMASK = 8'h3F;
endpackage

// File: rtl/pad_cfg_bank.sv
// pad_cfg_bank: shadow/active config storage with write port, registered read and diff mask
module pad_cfg_bank
   import pad_cfg_pkg::*;
#(
   parameter int NUM_PADS = 72
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          wr_en,
   input  logic                          rd_en,
   input  logic                          apply,
   input  logic [7:0]                    addr,
   input  logic [7:0]                    wdata,
   output logic                          rvalid,
   output logic [7:0]                    rdata,
   output pad_cfg_t [NUM_PADS-1:0]       active,
   output logic [NUM_PADS-1:0]           diff
);
   pad_cfg_t [NUM_PADS-1:0] shadow;
   logic [6:0] idx;
   logic       in_range;
   logic [7:0] wmask;
   logic       unused_rsvd;

   assign idx         = addr[6:0];
   assign in_range    = int'(idx) < NUM_PADS;
   assign wmask       = wdata & CFG_WMASK;
   assign unused_rsvd = ^wmask[7:6];

   for (genvar i = 0; i < NUM_PADS; i++) begin : g_diff
      assign diff[i] = shadow[i] != active[i];
   end

   // software writes land in shadow; apply copies the whole shadow bank into active at once
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shadow <= '0;
         active <= '0;
      end else begin
         if (wr_en && in_range) shadow[idx] <= pad_cfg_t'(wmask[5:0]);
         if (apply) active <= shadow;
      end
   end

   // read data returns one cycle after the grant; out-of-range pads read as zero
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rvalid <= 1'b0;
         rdata  <= 8'h00;
      end else begin
         rvalid <= rd_en;
         rdata  <= (rd_en && in_range) ? {2'b00, addr[7] ? active[idx] : shadow[idx]} : 8'h00;
      end
   end
endmodule

// File: rtl/pad_cfg_ctrl.sv
// pad_cfg_ctrl: pad drive/slew/pull configuration with power-up and glitch-free commit sequencing
module pad_cfg_ctrl
   import pad_cfg_pkg::*;
#(
   parameter int NUM_PADS      = 72,
   parameter int PWRUP_CYCLES  = 256,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                cfg_req_i,
   input  logic                cfg_we_i,
   input  logic [7:0]          cfg_addr_i,
   input  logic [7:0]          cfg_wdata_i,
   output logic                cfg_gnt_o,
   output logic                cfg_rvalid_o,
   output logic [7:0]          cfg_rdata_o,
   input  logic                commit_i,
   output logic                busy_o,
   output logic [NUM_PADS-1:0] drv0_o,
   output logic [NUM_PADS-1:0] drv1_o,
   output logic [NUM_PADS-1:0] drv2_o,
   output logic [NUM_PADS-1:0] prg_slew_o,
   output logic [NUM_PADS-1:0] pd_o,
   output logic [NUM_PADS-1:0] puq_o,
   output logic [NUM_PADS-1:0] pwrup_pull_en_o,
   output logic [NUM_PADS-1:0] pwrupzhl_o,
   output logic [NUM_PADS-1:0] out_hold_o
);
   localparam int CNT_MAX = PWRUP_CYCLES > SETTLE_CYCLES ? PWRUP_CYCLES : SETTLE_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   state_t                  state, nstate;
   logic [CW-1:0]           cnt, ncnt;
   logic                    pending, npending;
   logic                    done, start, apply;
   logic [NUM_PADS-1:0]     mask, diff;
   pad_cfg_t [NUM_PADS-1:0] active;

   assign done      = cnt == (state == PWRUP ? CW'(PWRUP_CYCLES - 1) : CW'(SETTLE_CYCLES - 1));
   assign start     = state == IDLE && (commit_i || pending);
   assign apply     = state == APPLY;
   assign cfg_gnt_o = cfg_req_i && !apply;
   assign busy_o    = state != IDLE || pending;

   pad_cfg_bank #(.NUM_PADS(NUM_PADS)) u_bank (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .wr_en  (cfg_gnt_o && cfg_we_i),
      .rd_en  (cfg_gnt_o && !cfg_we_i),
      .apply  (apply),
      .addr   (cfg_addr_i),
      .wdata  (cfg_wdata_i),
      .rvalid (cfg_rvalid_o),
      .rdata  (cfg_rdata_o),
      .active (active),
      .diff   (diff)
   );

   // sequence power-up, then hold -> apply -> release for every commit; counter restarts on each state change
   always_comb begin
      nstate = state;
      unique case (state)
         PWRUP:   nstate = done ? IDLE : PWRUP;
         IDLE:    nstate = start ? HOLD : IDLE;
         HOLD:    nstate = done ? APPLY : HOLD;
         APPLY:   nstate = RELEASE;
         RELEASE: nstate = done ? IDLE : RELEASE;
      endcase
      ncnt     = nstate != state ? '0 : (&cnt ? cnt : cnt + 1'b1);
      npending = state == IDLE ? 1'b0 : (pending || commit_i);
   end

   // state, counter, pending commit and the hold mask latched when a sequence begins
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= PWRUP;
         cnt     <= '0;
         pending <= 1'b0;
         mask    <= '0;
      end else begin
         state   <= nstate;
         cnt     <= ncnt;
         pending <= npending;
         if (start) mask <= diff;
      end
   end

   for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
      assign drv0_o[i]     = active[i].drv[0];
      assign drv1_o[i]     = active[i].drv[1];
      assign drv2_o[i]     = active[i].drv[2];
      assign prg_slew_o[i] = active[i].slew;
      assign pd_o[i]       = active[i].pd;
      assign puq_o[i]      = ~active[i].pu;
   end

   assign pwrup_pull_en_o = {NUM_PADS{state == PWRUP}};
   assign pwrupzhl_o      = {NUM_PADS{state == PWRUP}};
   assign out_hold_o      = state == PWRUP ? '1 : (state == IDLE ? '0 : mask);
endmodule
